mem_access_ctrl: RTL and testbench

- Parametrised memory-access controller sitting between the execute and writeback stages of the RISC-V pipeline.
- Decodes each load/store address into the DMEM, IMEM or memory-mapped IO regions, and generates byte-lane write enables with lane-aligned write data.
- Runs a valid/ready handshake with NUM_IO IO channels, stalling the pipeline until each IO access completes or times out.
- Aligns and sign/zero-extends load data for writeback.

---
 rtl/mem_access_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store region decode, byte-lane writes, IO handshake FSM and load alignment.
// Ports: clk/rst (sync, active-high); req_* request from execute; stall holds the pipeline;
// dmem_we/imem_we/mem_wdata drive the local memories; dmem_rdata returns one cycle later;
// io_tx_*/io_rx_* per-channel valid/ready, io_be/io_wdata/io_rdata shared IO bus;
// ld_data/ld_valid writeback result; misalign_err pulse; io_timeout sticky abort flag.
// Optional MEMCTRL_STATS_EN adds stat_loads/stat_stores/stat_misalign counters.
module mem_access_ctrl #(
  parameter int NUM_IO     = 2,
  parameter int IO_SEL_LSB = 2,
  parameter int IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_kill,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [3:0]        dmem_we,
  output logic [3:0]        imem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       dmem_rdata,
  output logic [NUM_IO-1:0] io_tx_valid,
  input  logic [NUM_IO-1:0] io_tx_ready,
  output logic [NUM_IO-1:0] io_rx_valid,
  input  logic [NUM_IO-1:0] io_rx_ready,
  input  logic [31:0]       io_rdata,
  output logic [3:0]        io_be,
  output logic [31:0]       io_wdata,
  output logic [31:0]       ld_data,
  output logic              ld_valid,
  output logic              misalign_err,
  output logic              io_timeout
`ifdef MEMCTRL_STATS_EN
  ,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_misalign
`endif
);
  localparam int CW = NUM_IO > 1 ? $clog2(NUM_IO) : 1;
  localparam logic [1:0] IDLE = 2'd0, IO_WAIT = 2'd1, DONE = 2'd2;
  localparam logic [NUM_IO-1:0] ONE = 1;
  logic [1:0] state;
  logic [CW-1:0] ch, ch_n;
  logic [3:0] mask, be;
  logic [31:0] wd, wbuf, cap, cnt, sh, ext;
  logic [2:0] fn;
  logic [1:0] off;
  logic io_ld, dpend, acc, mis, dm, im, io, start, rdy, tmo;
  logic unused_addr;
  assign unused_addr = ^req_addr;
  always_comb begin
    acc = req_valid & ~req_kill & (state == IDLE) & (req_load | req_store);
    mis = (req_funct3[1:0] == 2'b01 & req_addr[0]) | (req_funct3[1:0] == 2'b10 & |req_addr[1:0]);
    mask = req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
           req_funct3[1:0] == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
         req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    dm = ~req_addr[31] & req_addr[28];
    im = ~req_addr[31] & req_addr[29];
    io = req_addr[31:28] == 4'b1000;
    start = acc & ~mis & io;
    ch_n = NUM_IO > 1 ? req_addr[IO_SEL_LSB +: CW] : '0;
    dmem_we = (acc & req_store & ~mis & dm) ? mask : 4'b0000;
    imem_we = (acc & req_store & ~mis & im) ? mask : 4'b0000;
    mem_wdata = wd;
    misalign_err = acc & mis;
    stall = start | (state == IO_WAIT);
    rdy = io_ld ? io_rx_ready[ch] : io_tx_ready[ch];
    tmo = (IO_TIMEOUT != 0) && (cnt == 32'(IO_TIMEOUT - 1));
    io_tx_valid = (state == IO_WAIT && !io_ld) ? ONE << ch : '0;
    io_rx_valid = (state == IO_WAIT && io_ld) ? ONE << ch : '0;
    io_be = be;
    io_wdata = wbuf;
    // A DMEM load result and an IO DONE can never coincide, so they share one aligner.
    ld_valid = dpend | (state == DONE & io_ld);
    sh = (state == DONE ? cap : dmem_rdata) >> {off, 3'b000};
    ext = fn == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
          fn == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
          fn == 3'b100 ? {24'b0, sh[7:0]} :
          fn == 3'b101 ? {16'b0, sh[15:0]} : sh;
    ld_data = ld_valid ? ext : 32'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dpend <= 1'b0;
      io_timeout <= 1'b0;
      ch <= '0;
      be <= '0;
      wbuf <= '0;
      cap <= '0;
      fn <= '0;
      off <= '0;
      io_ld <= 1'b0;
    end else begin
      dpend <= acc & ~mis & req_load & dm;
      if (acc & req_load) begin
        fn <= req_funct3;
        off <= req_addr[1:0];
      end
      case (state)
        IDLE: if (start) begin
          state <= IO_WAIT;
          cnt <= '0;
          ch <= ch_n;
          be <= mask;
          wbuf <= wd;
          io_ld <= req_load;
        end
        IO_WAIT: begin
          cnt <= cnt + 32'd1;
          if (rdy) begin
            state <= DONE;
            cap <= io_rdata;
          end else if (tmo) begin
            state <= DONE;
            cap <= '0;
            io_timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef MEMCTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads <= '0;
      stat_stores <= '0;
      stat_misalign <= '0;
    end else begin
      stat_loads <= stat_loads + 32'(acc & req_load);
      stat_stores <= stat_stores + 32'(acc & req_store);
      stat_misalign <= stat_misalign + 32'(acc & mis);
    end
  end
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks of mem_access_ctrl against a behavioural model.
module tb_mem_access_ctrl;
  localparam int TMO = 4;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_kill = 0, req_load = 0, req_store = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, dmem_rdata = 0, io_rdata = 0;
  logic [1:0] io_tx_ready = 0, io_rx_ready = 0;
  logic stall, ld_valid, misalign_err, io_timeout;
  logic [3:0] dmem_we, imem_we, io_be;
  logic [31:0] mem_wdata, io_wdata, ld_data;
  logic [1:0] io_tx_valid, io_rx_valid;
`ifdef MEMCTRL_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_misalign;
`endif
  int n_chk = 0, n_fail = 0;
  bit m_tmo = 0;
  mem_access_ctrl #(.NUM_IO(2), .IO_SEL_LSB(2), .IO_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_kill(req_kill), .req_load(req_load),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .dmem_we(dmem_we), .imem_we(imem_we), .mem_wdata(mem_wdata),
    .dmem_rdata(dmem_rdata), .io_tx_valid(io_tx_valid), .io_tx_ready(io_tx_ready),
    .io_rx_valid(io_rx_valid), .io_rx_ready(io_rx_ready), .io_rdata(io_rdata), .io_be(io_be),
    .io_wdata(io_wdata), .ld_data(ld_data), .ld_valid(ld_valid), .misalign_err(misalign_err),
    .io_timeout(io_timeout)
`ifdef MEMCTRL_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_misalign(stat_misalign)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [2:0] f, input int o);
    int unsigned s = w >> (8 * o);
    int unsigned b = s % 256, h = s % 65536;
    case (f)
      3'd0: return b >= 128 ? b + 32'hFFFF_FF00 : b;
      3'd1: return h >= 32768 ? h + 32'hFFFF_0000 : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction
  function automatic logic [3:0] m_mask(input logic [2:0] f, input int o);
    if (f % 4 == 0) return 4'(1 << o);
    if (f % 4 == 1) return o >= 2 ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction
  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] w);
    if (f % 4 == 0) return (w % 256) * 32'h0101_0101;
    if (f % 4 == 1) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction
  function automatic bit m_mis(input logic [2:0] f, input int o);
    return ((f % 4 == 1) && (o % 2 != 0)) || ((f % 4 == 2) && o != 0);
  endfunction
  task automatic set_req(input bit v, k, l, s, input logic [2:0] f, input logic [31:0] a, w);
    req_valid = v; req_kill = k; req_load = l; req_store = s; req_funct3 = f; req_addr = a; req_wdata = w;
  endtask
  task automatic test_reset;
    rst = 1;
    set_req(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (stall !== 0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    n_chk++; if ({dmem_we, imem_we} !== 0) begin n_fail++; $display("FAIL reset_we got %h want 0", {dmem_we, imem_we}); end
    n_chk++; if ({io_tx_valid, io_rx_valid} !== 0) begin n_fail++; $display("FAIL reset_io_valid got %b want 0", {io_tx_valid, io_rx_valid}); end
    n_chk++; if ({ld_valid, misalign_err, io_timeout} !== 0) begin n_fail++; $display("FAIL reset_flags got %b want 000", {ld_valid, misalign_err, io_timeout}); end
    n_chk++; if (ld_data !== 0) begin n_fail++; $display("FAIL reset_ld_data got %h want 0", ld_data); end
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_mem_store;
    @(negedge clk);
    set_req(1, 0, 0, 1, 3'd0, 32'h1000_0003, 32'h0000_00AB);
    #1;
    n_chk++; if (dmem_we !== 4'b1000) begin n_fail++; $display("FAIL sb_dmem_we got %b want 1000", dmem_we); end
    n_chk++; if (mem_wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata got %h want ababab", mem_wdata); end
    n_chk++; if (imem_we !== 0 || stall !== 0) begin n_fail++; $display("FAIL sb_imem_stall got %b/%b want 0000/0", imem_we, stall); end
    @(negedge clk);
    set_req(1, 0, 0, 1, 3'd1, 32'h3000_0002, 32'h0000_1234);
    #1;
    n_chk++; if (dmem_we !== 4'b1100 || imem_we !== 4'b1100) begin n_fail++; $display("FAIL sh_both_we got %b/%b want 1100/1100", dmem_we, imem_we); end
    n_chk++; if (mem_wdata !== 32'h1234_1234) begin n_fail++; $display("FAIL sh_wdata got %h want 12341234", mem_wdata); end
    req_kill = 1;
    #1;
    n_chk++; if (dmem_we !== 0 || imem_we !== 0) begin n_fail++; $display("FAIL sh_kill_we got %b/%b want 0000/0000", dmem_we, imem_we); end
    @(negedge clk);
    set_req(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_mem_load;
    for (int u = 0; u < 2; u++) begin
      @(negedge clk);
      set_req(1, 0, 1, 0, u ? 3'd4 : 3'd0, 32'h1000_0001, 0);
      #1;
      n_chk++; if (ld_valid !== 0 || stall !== 0) begin n_fail++; $display("FAIL lb_accept got %b/%b want 0/0", ld_valid, stall); end
      @(negedge clk);
      set_req(0, 0, 0, 0, 0, 0, 0);
      dmem_rdata = 32'h0000_8000;
      #1;
      n_chk++; if (ld_valid !== 1) begin n_fail++; $display("FAIL lb_valid got %b want 1", ld_valid); end
      n_chk++; if (ld_data !== (u ? 32'h0000_0080 : 32'hFFFF_FF80)) begin n_fail++; $display("FAIL lb_data got %h want %h", ld_data, u ? 32'h80 : 32'hFFFF_FF80); end
    end
  endtask
  task automatic test_io_store;
    logic [31:0] w = $urandom;
    @(negedge clk);
    set_req(1, 0, 0, 1, 3'd2, 32'h8000_0004, w);
    #1;
    n_chk++; if (stall !== 1) begin n_fail++; $display("FAIL ios_accept_stall got %b want 1", stall); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      io_tx_ready = i == 2 ? 2'b10 : 2'b01;
      #1;
      n_chk++; if (stall !== 1) begin n_fail++; $display("FAIL ios_wait_stall got %b want 1", stall); end
      n_chk++; if (io_tx_valid !== 2'b10 || io_rx_valid !== 0) begin n_fail++; $display("FAIL ios_valid got %b/%b want 10/00", io_tx_valid, io_rx_valid); end
      n_chk++; if (io_be !== 4'b1111 || io_wdata !== w) begin n_fail++; $display("FAIL ios_bus got %b/%h want 1111/%h", io_be, io_wdata, w); end
    end
    @(negedge clk);
    io_tx_ready = 0;
    #1;
    n_chk++; if (stall !== 0 || io_tx_valid !== 0 || ld_valid !== 0) begin n_fail++; $display("FAIL ios_done got %b/%b/%b want 0/00/0", stall, io_tx_valid, ld_valid); end
    @(negedge clk);
    set_req(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_io_timeout;
    io_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    set_req(1, 0, 1, 0, 3'd2, 32'h8000_0000, 0);
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      #1;
      n_chk++; if (io_rx_valid !== 2'b01 || stall !== 1) begin n_fail++; $display("FAIL tmo_wait got %b/%b want 01/1", io_rx_valid, stall); end
    end
    @(negedge clk);
    #1;
    n_chk++; if (stall !== 0 || io_rx_valid !== 0) begin n_fail++; $display("FAIL tmo_done got %b/%b want 0/00", stall, io_rx_valid); end
    n_chk++; if (ld_valid !== 1 || ld_data !== 0) begin n_fail++; $display("FAIL tmo_result got %b/%h want 1/0", ld_valid, ld_data); end
    n_chk++; if (io_timeout !== 1) begin n_fail++; $display("FAIL tmo_flag got %b want 1", io_timeout); end
    @(negedge clk);
    set_req(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    set_req(1, 0, 1, 0, 3'd2, 32'h8000_0000, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    set_req(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_chk++; if (io_rx_valid !== 0 || stall !== 0) begin n_fail++; $display("FAIL rst_mid_wait got %b/%b want 00/0", io_rx_valid, stall); end
    n_chk++; if (io_timeout !== 0) begin n_fail++; $display("FAIL rst_tmo_clear got %b want 0", io_timeout); end
    m_tmo = 0;
  endtask
  task automatic test_misalign;
`ifdef MEMCTRL_STATS_EN
    logic [31:0] before = stat_misalign;
`endif
    @(negedge clk);
    set_req(1, 0, 1, 0, 3'd2, 32'h1000_0002, 0);
    #1;
    n_chk++; if (misalign_err !== 1) begin n_fail++; $display("FAIL mis_pulse got %b want 1", misalign_err); end
    n_chk++; if ({dmem_we, imem_we} !== 0 || stall !== 0) begin n_fail++; $display("FAIL mis_enables got %h/%b want 0/0", {dmem_we, imem_we}, stall); end
    @(negedge clk);
    set_req(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_chk++; if (ld_valid !== 0 || misalign_err !== 0) begin n_fail++; $display("FAIL mis_after got %b/%b want 0/0", ld_valid, misalign_err); end
`ifdef MEMCTRL_STATS_EN
    n_chk++; if (stat_misalign !== before + 1) begin n_fail++; $display("FAIL mis_stat got %0d want %0d", stat_misalign, before + 1); end
`endif
  endtask
  task automatic test_random;
    for (int n = 0; n < 300; n++) begin
      bit l = 1'($urandom_range(0, 1));
      int r = $urandom_range(0, 3);
      int idx = $urandom_range(0, l ? 4 : 2);
      logic [2:0] f = 3'(idx < 3 ? idx : idx + 1);
      logic [3:0] hi = r == 0 ? 4'h1 : r == 1 ? 4'h2 : r == 2 ? 4'h3 : 4'h8;
      logic [31:0] a = {hi, 28'($urandom)};
      logic [31:0] w = $urandom;
      bit k = $urandom_range(0, 7) == 0;
      int o = a % 4;
      int ch = (a / 4) % 2;
      bit mis = m_mis(f, o);
      bit ok = !k && !mis;
      bit dreg = (r == 0 || r == 2);
      bit ireg = (r == 1 || r == 2);
      @(negedge clk);
      set_req(1, k, l, !l, f, a, w);
      #1;
      n_chk++; if (dmem_we !== ((ok && !l && dreg) ? m_mask(f, o) : 4'd0)) begin n_fail++; $display("FAIL rnd_dmem_we got %b want %b", dmem_we, (ok && !l && dreg) ? m_mask(f, o) : 4'd0); end
      n_chk++; if (imem_we !== ((ok && !l && ireg) ? m_mask(f, o) : 4'd0)) begin n_fail++; $display("FAIL rnd_imem_we got %b want %b", imem_we, (ok && !l && ireg) ? m_mask(f, o) : 4'd0); end
      n_chk++; if (misalign_err !== (!k && mis) || stall !== (ok && r == 3)) begin n_fail++; $display("FAIL rnd_err_stall got %b/%b want %b/%b", misalign_err, stall, !k && mis, ok && r == 3); end
      if (!l) begin
        n_chk++; if (mem_wdata !== m_wdata(f, w)) begin n_fail++; $display("FAIL rnd_wdata got %h want %h", mem_wdata, m_wdata(f, w)); end
      end
      if (ok && r == 3) begin
        int lat = $urandom_range(0, 5);
        logic [31:0] rd = $urandom, res = 0;
        logic [1:0] sel = 2'(1 << ch);
        bit done = 0;
        for (int i = 0; !done; i++) begin
          @(negedge clk);
          req_kill = 1'($urandom);
          io_rdata = i == lat ? rd : $urandom;
          io_tx_ready = 2'($urandom);
          io_rx_ready = 2'($urandom);
          if (l) io_rx_ready[ch] = i == lat; else io_tx_ready[ch] = i == lat;
          #1;
          n_chk++; if (stall !== 1) begin n_fail++; $display("FAIL rnd_io_stall got %b want 1", stall); end
          n_chk++; if (io_tx_valid !== (l ? 2'b00 : sel) || io_rx_valid !== (l ? sel : 2'b00)) begin n_fail++; $display("FAIL rnd_io_valid got %b/%b want %b/%b", io_tx_valid, io_rx_valid, l ? 2'b00 : sel, l ? sel : 2'b00); end
          n_chk++; if (io_be !== m_mask(f, o)) begin n_fail++; $display("FAIL rnd_io_be got %b want %b", io_be, m_mask(f, o)); end
          if (!l) begin
            n_chk++; if (io_wdata !== m_wdata(f, w)) begin n_fail++; $display("FAIL rnd_io_wdata got %h want %h", io_wdata, m_wdata(f, w)); end
          end
          if (i == lat) begin done = 1; res = m_ext(rd, f, o); end
          else if (i == TMO - 1) begin done = 1; res = 0; m_tmo = 1; end
        end
        @(negedge clk);
        io_tx_ready = 0;
        io_rx_ready = 0;
        #1;
        n_chk++; if (stall !== 0 || io_tx_valid !== 0 || io_rx_valid !== 0) begin n_fail++; $display("FAIL rnd_done got %b/%b/%b want 0/00/00", stall, io_tx_valid, io_rx_valid); end
        n_chk++; if (ld_valid !== l) begin n_fail++; $display("FAIL rnd_io_ld_valid got %b want %b", ld_valid, l); end
        if (l) begin
          n_chk++; if (ld_data !== res) begin n_fail++; $display("FAIL rnd_io_ld_data got %h want %h", ld_data, res); end
        end
        n_chk++; if (io_timeout !== m_tmo) begin n_fail++; $display("FAIL rnd_io_timeout got %b want %b", io_timeout, m_tmo); end
      end
      @(negedge clk);
      set_req(0, 0, 0, 0, 0, 0, 0);
      dmem_rdata = $urandom;
      #1;
      n_chk++; if (ld_valid !== (ok && l && dreg) || misalign_err !== 0) begin n_fail++; $display("FAIL rnd_ld_valid got %b/%b want %b/0", ld_valid, misalign_err, ok && l && dreg); end
      if (ok && l && dreg) begin
        n_chk++; if (ld_data !== m_ext(dmem_rdata, f, o)) begin n_fail++; $display("FAIL rnd_ld_data got %h want %h", ld_data, m_ext(dmem_rdata, f, o)); end
      end
    end
  endtask
  initial begin
    test_reset;
    test_mem_store;
    test_mem_load;
    test_io_store;
    test_io_timeout;
    test_misalign;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
